shift_unit_seq: RTL and testbench
=================================

SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 The block SHALL have exactly these ports, one per line below; the clock and reset ports SHALL come first.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a shift; sampled only in IDLE.
REQ-005 op  input  2  shift kind: 00 SLL, 01 SRL, 10 SRA, 11 reserved (pass-through).
REQ-006 shamt  input  5  shift amount, 0..31.
REQ-007 shift_in  input  32  operand, driven by the shift-source select (rt, rs or the 16-bit-shifted immediate).
REQ-008 shift_out  output  32  result register.
REQ-009 busy  output  1  high while the operation is in progress.
REQ-010 done  output  1  one-cycle completion pulse.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 In IDLE, start=1 at a clock edge SHALL capture the operands and move to SHIFT:
- shift_in into shift_out;
- shamt into a 5-bit counter;
- op into an op register.
REQ-013 start SHALL be ignored in SHIFT and DONE; inputs changing after capture SHALL have no effect.
REQ-014 In SHIFT, each edge with counter != 0 SHALL shift shift_out by one bit and decrement the counter:
- SLL: zero fill at bit 0;
- SRL: zero fill at bit 31;
- SRA: bit 31 replicated;
- op 11: value unchanged.
REQ-015 In SHIFT, the edge on which counter == 0 SHALL move to DONE without modifying shift_out.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency: for a start accepted at edge E0, shift k SHALL occur at edge E0+k (k=1..shamt).
REQ-018 done SHALL be 1 only after edge E0+shamt+1, i.e. while in DONE; total occupancy is shamt+2 cycles.
REQ-019 busy SHALL be 1 exactly while in SHIFT; busy and done SHALL never both be 1.
REQ-020 shamt=0 SHALL produce done one cycle after the SHIFT cycle, with shift_out == shift_in.
REQ-021 shift_out SHALL hold its value in DONE and IDLE until the next accepted start.
REQ-022 Shift amounts above 31 are unrepresentable; shamt=31 SHALL complete normally. SRA by 31 SHALL yield all copies of the original bit 31.
REQ-023 start held high continuously SHALL begin a new operation on the first IDLE edge after DONE, giving back-to-back operations with one IDLE cycle between them.

Reset
REQ-024 reset_n=0 SHALL immediately, without a clock, force state IDLE, shift_out=0, counter=0, op register=00, busy=0, done=0.
REQ-025 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no done pulse.
REQ-026 After reset deasserts, the first start seen at an edge SHALL be accepted normally.

Structure
REQ-027 A shared package SHALL hold:
- the op encodings (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_PASS);
- the FSM state encoding;
- the width constants DATA_W=32 and SHAMT_W=5.
REQ-028 One combinational sub-module, shift_step, SHALL compute the single-bit shift from (op, value).
REQ-029 shift_unit_seq SHALL contain the FSM, the counter and the registers.
REQ-030 Implementation size: 120-400 lines of RTL.

Verification
REQ-031 SLL: shift_in=0x0000_0001, shamt=4, op=00 -> busy for 5 cycles, then done pulse, shift_out=0x0000_0010.
REQ-032 SRA: shift_in=0x8000_0000, shamt=31, op=10 -> shift_out=0xFFFF_FFFF, done 32 edges after acceptance; SRL with the same inputs -> 0x0000_0001.
REQ-033 shamt=0: shift_in=0xDEAD_BEEF, op=01 -> done after 2 edges, shift_out=0xDEAD_BEEF; op=11 with shamt=7 -> 0xDEAD_BEEF.
REQ-034 Ignored start: start pulsed in SHIFT with new shift_in=0x1234_5678 -> result is unaffected; start held high -> a new capture on the first IDLE edge after DONE.
REQ-035 Mid-operation reset: reset_n=0 at the third SHIFT cycle of an SLL by 10 -> outputs 0 immediately and no done pulse; next start completes correctly.
REQ-036 The bench SHALL check busy/done exclusivity and done pulse width = 1 on every cycle of every scenario.

Source files
------------

// File: rtl/shift_unit_seq_pkg.sv
// Shared definitions for the sequential shift unit: widths, op codes, FSM states.
package shift_unit_seq_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  // Shift kind; the reserved code leaves the operand untouched.
  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_PASS = 2'b11
  } shift_op_e;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_unit_seq_step.sv
// One-bit shift of a word according to the shift kind (purely combinational).
module shift_step
  import shift_unit_seq_pkg::*;
(
  input  shift_op_e         op,
  input  logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] result
);

  // Select fill bit and direction for a single-position shift.
  always_comb begin
    result = value;
    case (op)
      SHIFT_SLL: result = {value[DATA_W-2:0], 1'b0};
      SHIFT_SRL: result = {1'b0, value[DATA_W-1:1]};
      SHIFT_SRA: result = {value[DATA_W-1], value[DATA_W-1:1]};
      default:   result = value;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Sequential shifter: one bit per clock, shamt+2 cycles total occupancy.
//
// Handshake: start is only looked at in IDLE; the operands are captured on
// that edge and may change freely afterwards. busy is high exactly while in
// SHIFT, done is a one-cycle pulse while in DONE, and the two are never high
// together. shift_out holds the result until the next accepted start.
module shift_unit_seq
  import shift_unit_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [4:0]        shamt,
  input  logic [31:0]       shift_in,
  output logic [31:0]       shift_out,
  output logic              busy,
  output logic              done
);

  state_e               state_q;
  state_e               state_d;
  logic [SHAMT_W-1:0]   cnt_q;
  shift_op_e            op_q;
  logic [DATA_W-1:0]    step_val;

  shift_step u_step (
    .op     (op_q),
    .value  (shift_out),
    .result (step_val)
  );

  // Next-state logic: SHIFT exits once the counter is exhausted; DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath: capture on accepted start, then one shift per edge while the counter is non-zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_out <= '0;
      cnt_q     <= '0;
      op_q      <= SHIFT_SLL;
    end else if (state_q == IDLE && start) begin
      shift_out <= shift_in;
      cnt_q     <= shamt;
      op_q      <= shift_op_e'(op);
    end else if (state_q == SHIFT && cnt_q != '0) begin
      shift_out <= step_val;
      cnt_q     <= cnt_q - 1'b1;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: cycle-accurate busy/done timing and results.
module tb_shift_unit_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] shift_in;
  logic [31:0] shift_out;
  logic        busy;
  logic        done;

  int n_asserts = 0;
  int n_fails   = 0;
  logic prev_done = 1'b0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  shift_unit_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .shamt     (shamt),
    .shift_in  (shift_in),
    .shift_out (shift_out),
    .busy      (busy),
    .done      (done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every cycle: busy/done exclusive and done never wider than one cycle.
  always @(negedge clk) begin
    check_eq("busy_done_excl", {31'b0, busy & done}, 32'd0);
    check_eq("done_width", {31'b0, done & prev_done}, 32'd0);
    prev_done = done;
  end

  // Driver: one full operation, checked cycle by cycle; optional poke with start in SHIFT.
  task automatic run_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d,
                        input bit poke);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    @(negedge clk);
    start = 1'b1; op = o; shamt = s; shift_in = d;
    @(negedge clk);
    start = 1'b0;
    check_eq("capture_val", shift_out, d);
    check_eq("busy_first", {31'b0, busy}, 32'd1);
    for (int i = 1; i <= s; i++) begin
      if (poke && i == 1) begin
        start = 1'b1; shift_in = 32'h1234_5678; op = 2'b11; shamt = 5'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check_eq("busy_shift", {30'b0, busy, done}, 32'd2);
    end
    start = 1'b0;
    @(negedge clk);
    check_eq("done_pulse", {30'b0, busy, done}, 32'd1);
    check_eq("result", shift_out, exp);
    @(negedge clk);
    check_eq("idle_after", {30'b0, busy, done}, 32'd0);
    check_eq("result_hold", shift_out, exp);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'b00, 5'd4,  32'h0000_0001, 32'h0000_0010};
    vecs[1] = '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[2] = '{2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001};
    vecs[3] = '{2'b01, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[4] = '{2'b11, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[5] = '{2'b10, 5'd4,  32'h7000_00F0, 32'h0700_000F};
    vecs[6] = '{2'b01, 5'd8,  32'hF000_0000, 32'h00F0_0000};
    vecs[7] = '{2'b00, 5'd1,  32'h8000_0001, 32'h0000_0002};

    reset_n = 1'b0; start = 1'b0; op = 2'b00; shamt = 5'd0; shift_in = 32'h0;
    #3;
    check_eq("reset_out", shift_out, 32'd0);
    check_eq("reset_flags", {30'b0, busy, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed vector table
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp);
      run_op(vecs[i].op, vecs[i].shamt, vecs[i].din, 1'b0);
    end

    // Start pulsed during SHIFT with new operands is ignored
    exp_q.push_back(32'h0000_0060);
    run_op(2'b00, 5'd5, 32'h0000_0003, 1'b1);

    // Start held high: back-to-back with one IDLE cycle between
    @(negedge clk);
    start = 1'b1; op = 2'b00; shamt = 5'd2; shift_in = 32'h0000_0001;
    repeat (3) begin
      @(negedge clk);
      check_eq("b2b_busy1", {30'b0, busy, done}, 32'd2);
    end
    shift_in = 32'h0000_0003; shamt = 5'd1;
    @(negedge clk);
    check_eq("b2b_done1", {30'b0, busy, done}, 32'd1);
    check_eq("b2b_res1", shift_out, 32'h0000_0004);
    @(negedge clk);
    check_eq("b2b_idle", {30'b0, busy, done}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check_eq("b2b_recapture", shift_out, 32'h0000_0003);
    check_eq("b2b_busy2", {30'b0, busy, done}, 32'd2);
    @(negedge clk);
    check_eq("b2b_busy2b", {30'b0, busy, done}, 32'd2);
    @(negedge clk);
    check_eq("b2b_done2", {30'b0, busy, done}, 32'd1);
    check_eq("b2b_res2", shift_out, 32'h0000_0006);
    @(negedge clk);

    // Mid-operation reset: SLL by 10, reset in the third SHIFT cycle
    start = 1'b1; op = 2'b00; shamt = 5'd10; shift_in = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("pre_reset_val", shift_out, 32'h0000_0004);
    reset_n = 1'b0;
    #1;
    check_eq("async_reset_out", shift_out, 32'd0);
    check_eq("async_reset_flags", {30'b0, busy, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check_eq("no_done_after_abort", {30'b0, busy, done}, 32'd0);
    end
    exp_q.push_back(32'h0000_0400);
    run_op(2'b00, 5'd10, 32'h0000_0001, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
